// File: rtl/lfo_wave_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : lfo_wave_gen_if
//  Description : Bundle carrying the LFO control inputs and its wave outputs.
//                master = the controller that drives configuration and
//                observes the wave; slave = the oscillator itself.
//  Signals     : en, sync, mode, rate, step, lo, hi  (master -> slave)
//                wav, upd, wrap, peak                (slave -> master)
//  Revision    : 1.0 - initial release
// ============================================================================
interface lfo_wave_gen_if #(
   parameter int N     = 8,
   parameter int DIV_W = 16
);
   logic             en;
   logic             sync;
   logic [1:0]       mode;
   logic [DIV_W-1:0] rate;
   logic [N-1:0]     step;
   logic [N-1:0]     lo;
   logic [N-1:0]     hi;
   logic [N-1:0]     wav;
   logic             upd;
   logic             wrap;
   logic             peak;

   modport master (
      output en, sync, mode, rate, step, lo, hi,
      input  wav, upd, wrap, peak
   );

   modport slave (
      input  en, sync, mode, rate, step, lo, hi,
      output wav, upd, wrap, peak
   );
endinterface
`default_nettype wire

// File: rtl/lfo_wave_gen.sv
`default_nettype none
// ============================================================================
//  Module      : lfo_wave_gen
//  Description : Multi-mode LFO (triangle, rising saw, falling saw, square)
//                with programmable bounds, step and update rate. Configuration
//                is captured only on rst, sync or at a wave-cycle wrap, so a
//                running wave is never disturbed mid-cycle.
//  Ports       : clk  - clock
//                rst  - synchronous active-high reset
//                bus  - lfo_wave_gen_if.slave (en, sync, mode, rate, step,
//                       lo, hi in; wav, upd, wrap, peak out)
//  Revision    : 1.0 - initial release
// ============================================================================
module lfo_wave_gen #(
   parameter int N     = 8,
   parameter int DIV_W = 16
) (
   input  wire logic        clk,
   input  wire logic        rst,
   lfo_wave_gen_if.slave    bus
);

   localparam logic [1:0] MODE_TRI    = 2'd0;
   localparam logic [1:0] MODE_SAW_UP = 2'd1;
   localparam logic [1:0] MODE_SAW_DN = 2'd2;
   localparam logic [1:0] MODE_SQR    = 2'd3;

   typedef enum logic {DIR_UP = 1'b0, DIR_DN = 1'b1} dir_t;

   logic [1:0]       mode_q, mode_d;
   logic [N-1:0]     lo_q,   lo_d;
   logic [N-1:0]     hi_q,   hi_d;
   logic [N-1:0]     step_q, step_d;
   logic [N-1:0]     ph_q,   ph_d;
   logic [N-1:0]     wav_q,  wav_d;
   dir_t             dir_q,  dir_d;
   logic [DIV_W-1:0] cnt_q,  cnt_d;
   logic             upd_q,  upd_d;
   logic             wrap_q, wrap_d;
   logic             peak_q, peak_d;

   // Start values derived from the live inputs, used by every load event.
   logic [N-1:0] w_ld_ph;
   logic [N-1:0] w_ld_wav;
   always_comb begin
      w_ld_ph = (bus.mode == MODE_SAW_DN) ? bus.hi : bus.lo;
      if (bus.lo >= bus.hi)
         w_ld_wav = bus.lo;                       // degenerate window pins wav to lo
      else if (bus.mode == MODE_SAW_DN || bus.mode == MODE_SQR)
         w_ld_wav = bus.hi;
      else
         w_ld_wav = bus.lo;
   end

   // One extra bit so ph+step and lo+step can never wrap around.
   logic [N:0] w_ph_up;
   logic [N:0] w_lo_step;
   logic [N:0] w_ph_ext;
   logic [N:0] w_hi_ext;
   logic       w_tick;
   logic       w_degen;
   logic       w_load;

   assign w_ph_up   = {1'b0, ph_q} + {1'b0, step_q};
   assign w_lo_step = {1'b0, lo_q} + {1'b0, step_q};
   assign w_ph_ext  = {1'b0, ph_q};
   assign w_hi_ext  = {1'b0, hi_q};
   assign w_tick    = bus.en && (cnt_q == bus.rate);
   assign w_degen   = (lo_q >= hi_q);

   always_comb begin
      mode_d = mode_q;
      lo_d   = lo_q;
      hi_d   = hi_q;
      step_d = step_q;
      ph_d   = ph_q;
      dir_d  = dir_q;
      wav_d  = wav_q;
      cnt_d  = cnt_q;
      upd_d  = 1'b0;
      wrap_d = 1'b0;
      peak_d = 1'b0;
      w_load = 1'b0;

      if (bus.sync) begin
         // Sync outranks a coincident tick and restarts the divider.
         w_load = 1'b1;
         cnt_d  = '0;
         upd_d  = 1'b1;
      end else if (bus.en) begin
         cnt_d = w_tick ? '0 : cnt_q + DIV_W'(1);
         if (w_tick) begin
            upd_d = 1'b1;
            if (!w_degen) begin
               case (mode_q)
                  MODE_SAW_UP: begin
                     if (w_ph_up > w_hi_ext) begin
                        w_load = 1'b1;
                        wrap_d = 1'b1;
                     end else begin
                        ph_d = w_ph_up[N-1:0];
                     end
                  end
                  MODE_SAW_DN: begin
                     if (w_ph_ext < w_lo_step) begin
                        w_load = 1'b1;
                        wrap_d = 1'b1;
                     end else begin
                        ph_d = ph_q - step_q;
                     end
                  end
                  default: begin
                     // Triangle engine, shared by TRI and SQR.
                     if (dir_q == DIR_UP) begin
                        if (w_ph_up >= w_hi_ext) begin
                           ph_d   = hi_q;
                           dir_d  = DIR_DN;
                           peak_d = 1'b1;
                        end else begin
                           ph_d = w_ph_up[N-1:0];
                        end
                     end else begin
                        if (w_ph_ext <= w_lo_step) begin
                           w_load = 1'b1;
                           wrap_d = 1'b1;
                        end else begin
                           ph_d = ph_q - step_q;
                        end
                     end
                  end
               endcase
            end
         end
      end

      if (w_load) begin
         mode_d = bus.mode;
         lo_d   = bus.lo;
         hi_d   = bus.hi;
         step_d = bus.step;
         ph_d   = w_ld_ph;
         dir_d  = DIR_UP;
         wav_d  = w_ld_wav;
      end else if (w_degen) begin
         wav_d = lo_q;
      end else if (mode_q == MODE_SQR) begin
         wav_d = (dir_d == DIR_UP) ? hi_q : lo_q;
      end else begin
         wav_d = ph_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mode_q <= bus.mode;
         lo_q   <= bus.lo;
         hi_q   <= bus.hi;
         step_q <= bus.step;
         ph_q   <= w_ld_ph;
         dir_q  <= DIR_UP;
         wav_q  <= w_ld_wav;
         cnt_q  <= '0;
         upd_q  <= 1'b0;
         wrap_q <= 1'b0;
         peak_q <= 1'b0;
      end else begin
         mode_q <= mode_d;
         lo_q   <= lo_d;
         hi_q   <= hi_d;
         step_q <= step_d;
         ph_q   <= ph_d;
         dir_q  <= dir_d;
         wav_q  <= wav_d;
         cnt_q  <= cnt_d;
         upd_q  <= upd_d;
         wrap_q <= wrap_d;
         peak_q <= peak_d;
      end
   end

   assign bus.wav  = wav_q;
   assign bus.upd  = upd_q;
   assign bus.wrap = wrap_q;
   assign bus.peak = peak_q;

endmodule
`default_nettype wire

// File: doc/lfo_wave_gen.md
Name: lfo_wave_gen

Overview:
Multi-mode low-frequency oscillator for the modulation effects (tremolo, vibrato, auto-wah). It generates triangle, rising saw, falling saw or square waves. Output bounds, step size and update rate are programmable. An internal rate divider replaces the external advance pulse. New configuration is applied only at a wave-cycle boundary or on an explicit sync, so a running effect never glitches mid-cycle.

Parameters:
N, 8, output sample width
DIV_W, 16, rate divider width

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
en  in  1  run enable; 0 freezes divider and wave
sync  in  1  phase restart; each high cycle restarts the wave
mode  in  2  0=TRI, 1=SAW_UP, 2=SAW_DN, 3=SQR
rate  in  DIV_W  wave advances once every rate+1 enabled clocks
step  in  N  amount added or subtracted per advance
lo  in  N  lower output bound
hi  in  N  upper output bound
wav  out  N  registered wave sample
upd  out  1  1-cycle pulse, high in the first cycle a new wav value is visible
wrap  out  1  1-cycle pulse, high in the first cycle of a new wave period
peak  out  1  1-cycle pulse, high when TRI/SQR turns from rising to falling

Behaviour:
- Config latch: mode_q, lo_q, hi_q, step_q are loaded from the inputs on a load event. Load events are rst, sync, or a wrap condition.
- Between load events, input changes have no effect.
- Start value on load:
  - TRI, SAW_UP: ph=lo.
  - SAW_DN, SQR: ph=lo for SQR, hi for SAW_DN.
  - dir=up in all modes.
  - wav = start value, where the SQR start value is hi.
- Reset values: cnt=0, upd=wrap=peak=0. wav, ph, dir and the config registers take the load values computed from the inputs present during rst.
- Divider: when en=1, a tick fires on a cycle with cnt==rate, and cnt goes to 0; otherwise cnt increments. When en=0, cnt holds and no tick fires.
- Latency: wav, upd, wrap and peak all change on the clock edge that ends the tick cycle. They are all mutually cycle-aligned.
- Arithmetic is done in N+1 bits; no overflow or underflow is permitted.
- TRI, on each tick:
  - Rising: if ph+step >= hi, then ph=hi, dir=down, peak=1. Otherwise ph+=step.
  - Falling: if ph <= lo+step, wrap condition. Otherwise ph-=step.
- SAW_UP, on each tick: if ph+step > hi, wrap condition. Otherwise ph+=step.
- SAW_DN, on each tick: if ph < lo+step, wrap condition. Otherwise ph-=step.
- SQR: runs the TRI engine on ph. wav = hi while dir=up, lo while dir=down. peak and wrap pulse exactly as in TRI.
- Output mapping: wav = ph in TRI, SAW_UP and SAW_DN.
- Wrap condition:
  - Performs a load event: the new config is latched, ph and dir go to the new start value.
  - wrap=1 and upd=1.
  - Any mode change takes effect here.
- Sync:
  - Has priority over a tick in the same cycle.
  - Performs a load event and sets cnt=0.
  - upd=1, wrap=0, peak=0.
  - Works when en=0.
- Degenerate config, lo_q >= hi_q:
  - wav is held at lo_q.
  - Ticks still pulse upd; no wrap or peak is generated.
  - The block leaves this state only via sync or rst.
- step_q=0: wav holds, upd pulses on each tick, and no wrap occurs.
- rst mid-operation: has priority over everything, including sync and tick. It applies the reset values in the next cycle.

Test Plan:
1. rst with TRI, lo=10, hi=20, step=4, rate=0, en=1 -> wav 10,14,18,20(peak),16,12,10(wrap),14; upd high every cycle.
2. SAW_UP, lo=0, hi=255, step=64, rate=2 -> one update every 3 clocks: 0,64,128,192,0(wrap); cnt check: upd spacing exactly 3.
3. SAW_DN, lo=0, hi=255, step=100, rate=0 -> 255,155,55,255(wrap); then SQR, lo=0, hi=200, step=50 -> wav 200 ×4 ticks, peak, 0 ×4 ticks, wrap, 200.
4. TRI running with lo=10, hi=20; mode changed to SAW_DN and hi to 30 mid-rise -> triangle completes unchanged; at wrap wav=30, then 26,22,...
5. sync asserted on the same cycle as a tick, mid-fall -> wav=lo_new, cnt=0, upd=1, wrap=0; next tick arrives after rate+1 clocks.
6. en=0 for 10 cycles -> wav and cnt frozen, no pulses. lo=hi=50 then sync -> wav=50 held, upd pulses, no wrap. rst mid-wave -> next cycle all pulses 0, wav=start value.
